// File: rtl/buf_rx_sink_if.sv
// Handshake and output-stream bundle between BUF, the receiver sink and its consumer.
// The master side is BUF plus the consumer; the slave side is the sink.
interface buf_rx_sink_if #(parameter int W = 32);
    logic         BtoR_REQ;
    logic         RtoB_ACK;
    logic [W-1:0] DO;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (output BtoR_REQ, DO, out_ready, input RtoB_ACK, out_valid, out_data);
    modport slave  (input BtoR_REQ, DO, out_ready, output RtoB_ACK, out_valid, out_data);
endinterface

// File: rtl/buf_rx_sink.sv
// Four-phase REQ/ACK receiver that captures DO into a first-word-fall-through FIFO.
// It also checks the stream for an incrementing sequence and flags handshake violations.
module buf_rx_sink #(
    parameter int DATA_DLY = 1,
    parameter int ACK_DLY  = 1,
    parameter int DEPTH    = 4,
    parameter int W        = 32
) (
    input  logic          clk,
    input  logic          rst,
    buf_rx_sink_if.slave  bus,
    output logic [15:0]   rx_count,
    output logic          seq_err,
    output logic          proto_err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT_LOW, RELEASE} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          ack;
    logic [W-1:0]  expVal;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   occ;
    logic [W-1:0]  head;
    logic          push, pop, full;

    assign full = (occ == (AW+1)'(DEPTH));
    assign push = (state == SETTLE) && bus.BtoR_REQ && (cnt == 4'd0);
    assign pop  = (occ != '0) && bus.out_ready;

    assign bus.RtoB_ACK  = ack;
    assign bus.out_valid = (occ != '0);
    assign bus.out_data  = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            expVal    <= '0;
            rx_count  <= '0;
            seq_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Full FIFO holds off the handshake by simply never acknowledging.
                    if (bus.BtoR_REQ && !full) begin
                        state <= SETTLE;
                        cnt   <= 4'(DATA_DLY - 1);
                    end
                end
                SETTLE: begin
                    if (!bus.BtoR_REQ) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ack    <= 1'b1;
                        state  <= WAIT_LOW;
                        if (bus.DO != expVal) seq_err <= 1'b1;
                        expVal <= bus.DO + W'(1);
                        if (rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
                    end
                end
                WAIT_LOW: begin
                    if (!bus.BtoR_REQ) begin
                        state <= RELEASE;
                        cnt   <= 4'(ACK_DLY - 1);
                    end
                end
                RELEASE: begin
                    if (bus.BtoR_REQ) proto_err <= 1'b1;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        ack   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= bus.DO;
    end

    // head is registered so it keeps the last word when the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
            head  <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + AW'(1);
            if (pop)  rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: ;
            endcase
            if (occ == '0) begin
                if (push) head <= bus.DO;
            end else if (pop) begin
                if (occ > (AW+1)'(1)) head <= mem[rdPtr + AW'(1)];
                else if (push)        head <= bus.DO;
            end
        end
    end
endmodule

// File: tb/tb_buf_rx_sink.sv
// Scoreboard bench for buf_rx_sink: two instances (fast and slow settle delay), directed transfers,
// with expected words queued at issue time and popped by a monitor whenever the sink outputs one.
module tb_buf_rx_sink;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    buf_rx_sink_if #(.W(32)) bus0 ();
    buf_rx_sink_if #(.W(32)) bus1 ();

    logic [15:0] cnt0, cnt1;
    logic        seq0, seq1, pro0, pro1;

    buf_rx_sink #(.DATA_DLY(1), .ACK_DLY(1), .DEPTH(4), .W(32)) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0.slave), .rx_count(cnt0), .seq_err(seq0), .proto_err(pro0));
    buf_rx_sink #(.DATA_DLY(3), .ACK_DLY(1), .DEPTH(4), .W(32)) dut1 (
        .clk(clk), .rst(rst1), .bus(bus1.slave), .rx_count(cnt1), .seq_err(seq1), .proto_err(pro1));

    int passCnt = 0;
    int totalCnt = 0;
    int pops0 = 0;
    int pops1 = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name);
        totalCnt++;
        $display("FAIL %s", name);
    endtask

    function automatic logic ackOf(input bit sel);
        return sel ? bus1.RtoB_ACK : bus0.RtoB_ACK;
    endfunction

    // Output monitors: every word leaving a sink must match the head of its scoreboard.
    always @(negedge clk) begin
        if (!rst0 && bus0.out_valid && bus0.out_ready) begin
            pops0++;
            if (q0.size() == 0) fail($sformatf("u0 unexpected word %0h", bus0.out_data));
            else chk("u0 out_data", bus0.out_data, q0.pop_front());
        end
        if (!rst1 && bus1.out_valid && bus1.out_ready) begin
            pops1++;
            if (q1.size() == 0) fail($sformatf("u1 unexpected word %0h", bus1.out_data));
            else chk("u1 out_data", bus1.out_data, q1.pop_front());
        end
    end

    task automatic setReq(input bit sel, input logic v, input logic [31:0] d);
        if (sel) begin bus1.BtoR_REQ = v; bus1.DO = d; end
        else     begin bus0.BtoR_REQ = v; bus0.DO = d; end
    endtask

    // Latencies are counted in edges from the cycle REQ is driven until ACK is seen changed.
    task automatic xfer(input bit sel, input logic [31:0] d, output int upLat, output int dnLat);
        int n;
        @(posedge clk); #1;
        setReq(sel, 1'b1, d);
        if (sel) q1.push_back(d); else q0.push_back(d);
        n = 0;
        while (!ackOf(sel) && n < 64) begin @(posedge clk); #1; n++; end
        if (n == 64) fail($sformatf("ack rise timeout word %0h", d));
        upLat = n;
        setReq(sel, 1'b0, d);
        n = 0;
        while (ackOf(sel) && n < 64) begin @(posedge clk); #1; n++; end
        if (n == 64) fail($sformatf("ack fall timeout word %0h", d));
        dnLat = n;
    endtask

    task automatic doReset(input bit sel);
        @(posedge clk); #1;
        if (sel) begin rst1 = 1'b1; bus1.BtoR_REQ = 1'b0; end
        else     begin rst0 = 1'b1; bus0.BtoR_REQ = 1'b0; end
        @(posedge clk); #1;
        if (sel) begin rst1 = 1'b0; q1.delete(); end
        else     begin rst0 = 1'b0; q0.delete(); end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int up, dn, p, n;
        logic seen;
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.BtoR_REQ = 1'b0; bus0.DO = '0; bus0.out_ready = 1'b0;
        bus1.BtoR_REQ = 1'b0; bus1.DO = '0; bus1.out_ready = 1'b0;
        waitCycles(3);
        rst0 = 1'b0; rst1 = 1'b0;
        waitCycles(1);

        // Reset state, then a single transfer of 0.
        chk("rst ack", bus0.RtoB_ACK, 0);
        chk("rst out_valid", bus0.out_valid, 0);
        chk("rst out_data", bus0.out_data, 0);
        chk("rst rx_count", cnt0, 0);
        chk("rst seq_err", seq0, 0);
        chk("rst proto_err", pro0, 0);
        bus0.out_ready = 1'b1;
        xfer(0, 32'd0, up, dn);
        chk("t1 ack rise lat", up, 2);
        chk("t1 ack fall lat", dn, 2);
        waitCycles(2);
        chk("t1 rx_count", cnt0, 1);
        chk("t1 seq_err", seq0, 0);
        chk("t1 proto_err", pro0, 0);
        chk("t1 words out", pops0, 1);

        // 100 back-to-back transfers.
        doReset(0);
        for (int i = 0; i < 100; i++) xfer(0, i, up, dn);
        waitCycles(3);
        chk("t2 rx_count", cnt0, 100);
        chk("t2 seq_err", seq0, 0);
        chk("t2 proto_err", pro0, 0);
        chk("t2 queue drained", q0.size(), 0);

        // Backpressure with a full FIFO.
        doReset(0);
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) xfer(0, i, up, dn);
        @(posedge clk); #1;
        setReq(0, 1'b1, 32'd4);
        q0.push_back(32'd4);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (bus0.RtoB_ACK) seen = 1'b1; end
        chk("t3 ack held low while full", seen, 0);
        p = pops0;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        chk("t3 one word popped", pops0 - p, 1);
        n = 0;
        while (!bus0.RtoB_ACK && n < 64) begin @(posedge clk); #1; n++; end
        chk("t3 ack after pop lat", n, 2);
        setReq(0, 1'b0, 32'd4);
        n = 0;
        while (bus0.RtoB_ACK && n < 64) begin @(posedge clk); #1; n++; end
        chk("t3 ack fall lat", n, 2);
        p = pops0;
        bus0.out_ready = 1'b1;
        waitCycles(8);
        chk("t3 occupancy drained", pops0 - p, 4);
        chk("t3 rx_count", cnt0, 5);

        // Sequence skip: 0, 1, 3, 4.
        doReset(0);
        xfer(0, 32'd0, up, dn);
        xfer(0, 32'd1, up, dn);
        chk("t4 seq_err before skip", seq0, 0);
        xfer(0, 32'd3, up, dn);
        chk("t4 seq_err on skip", seq0, 1);
        xfer(0, 32'd4, up, dn);
        waitCycles(3);
        chk("t4 seq_err sticky", seq0, 1);
        chk("t4 rx_count", cnt0, 4);
        chk("t4 proto_err", pro0, 0);

        // Early REQ drop on the slow-settle instance.
        @(posedge clk); #1;
        setReq(1, 1'b1, 32'd7);
        waitCycles(2);
        setReq(1, 1'b0, 32'd7);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (bus1.RtoB_ACK) seen = 1'b1; end
        chk("t5 proto_err", pro1, 1);
        chk("t5 ack never rose", seen, 0);
        chk("t5 out_valid", bus1.out_valid, 0);
        chk("t5 rx_count", cnt1, 0);
        bus1.out_ready = 1'b1;
        xfer(1, 32'd0, up, dn);
        chk("t5 ack rise lat", up, 4);
        chk("t5 ack fall lat", dn, 2);
        waitCycles(2);
        chk("t5 rx_count after", cnt1, 1);
        chk("t5 seq_err", seq1, 0);
        chk("t5 words out", pops1, 1);

        // Reset mid-handshake with two words buffered.
        bus0.out_ready = 1'b0;
        xfer(0, 32'd0, up, dn);
        @(posedge clk); #1;
        setReq(0, 1'b1, 32'd1);
        q0.push_back(32'd1);
        n = 0;
        while (!bus0.RtoB_ACK && n < 64) begin @(posedge clk); #1; n++; end
        chk("t6 in WAIT_LOW", bus0.RtoB_ACK, 1);
        chk("t6 buffered", bus0.out_valid, 1);
        doReset(0);
        chk("t6 ack", bus0.RtoB_ACK, 0);
        chk("t6 out_valid", bus0.out_valid, 0);
        chk("t6 rx_count", cnt0, 0);
        chk("t6 seq_err", seq0, 0);
        chk("t6 proto_err", pro0, 0);
        bus0.out_ready = 1'b1;
        xfer(0, 32'd0, up, dn);
        waitCycles(3);
        chk("t6 seq_err after", seq0, 0);
        chk("t6 rx_count after", cnt0, 1);
        chk("t6 queue drained", q0.size(), 0);
        chk("u1 queue drained", q1.size(), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/buf_rx_sink.md
Name: buf_rx_sink

Overview:
- Synthesizable, clocked receiver stage directly downstream of the BUF handshake block.
- Consumes the four-phase BtoR_REQ/RtoB_ACK handshake and samples DO.
- Pushes each received word into a small first-word-fall-through FIFO for the next consumer.
- Checks the data stream is the incrementing sequence 0, 1, 2, ...; keeps a received-word count and sticky error flags usable as simulation checkers.

Parameters:
- DATA_DLY, 1, cycles from sampling REQ high to capturing DO and raising RtoB_ACK (legal range 1..15).
- ACK_DLY, 1, cycles from sampling REQ low to dropping RtoB_ACK (legal range 1..15).
- DEPTH, 4, FIFO depth in words (power of two, minimum 2).
- W, 32, data width.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- rst, input, 1, synchronous, active-high reset.
- BtoR_REQ, input, 1, request from BUF.
- DO, input, W, data from BUF; valid while BtoR_REQ is high.
- RtoB_ACK, output, 1, acknowledge to BUF (registered).
- out_valid, output, 1, FIFO not empty.
- out_ready, input, 1, downstream consumer accepts the head word.
- out_data, output, W, FIFO head word.
- rx_count, output, 16, words captured; saturates at 16'hFFFF.
- seq_err, output, 1, sticky: a captured word differed from the expected value.
- proto_err, output, 1, sticky: handshake violation.

Behaviour:
- Reset is sampled on the clk edge:
  - RtoB_ACK = 0, out_valid = 0, out_data = 0, rx_count = 0, seq_err = 0, proto_err = 0.
  - Expected value = 0, FIFO emptied, state = IDLE.
  - rst has priority over every other event, including mid-handshake; RtoB_ACK is low after the reset edge.
- State machine (a 4-bit delay counter, cnt, is shared between SETTLE and RELEASE):
  - IDLE:
    - If BtoR_REQ = 1 and FIFO occupancy < DEPTH, go to SETTLE with cnt = DATA_DLY-1.
    - If BtoR_REQ = 1 and the FIFO is full, stay in IDLE with RtoB_ACK held low (backpressure).
    - The full check uses the registered occupancy; a pop in the same cycle does not count.
  - SETTLE:
    - If BtoR_REQ = 0, set proto_err and return to IDLE with no capture.
    - Otherwise, if cnt != 0, decrement cnt.
    - Otherwise (cnt = 0):
      - Capture DO and push it into the FIFO.
      - Run the sequence check and increment rx_count.
      - Set RtoB_ACK to 1 and go to WAIT_LOW.
    - Net effect: the capture edge is DATA_DLY edges after the edge that sampled REQ high.
  - WAIT_LOW: RtoB_ACK = 1. When BtoR_REQ = 0 is sampled, go to RELEASE with cnt = ACK_DLY-1.
  - RELEASE:
    - If BtoR_REQ = 1, set proto_err, but the release still completes.
    - If cnt != 0, decrement cnt.
    - Otherwise, set RtoB_ACK to 0 and go to IDLE.
- Sequence check, on the capture edge only:
  - If DO != expected, set seq_err (sticky until rst).
  - Expected becomes DO+1 mod 2^W, so the check resyncs after a skip and does not cascade errors.
  - Wrap from all-ones to 0 is legal.
- FIFO:
  - First-word fall-through: out_data is the head word and is valid in the same cycle out_valid is high.
  - Pop when out_valid and out_ready are both high.
  - A push and a pop in the same cycle are allowed; occupancy stays unchanged.
  - A pop when empty is ignored.
  - A push into a full FIFO cannot occur, because of the IDLE gate.
  - Pointers are log2(DEPTH) bits with natural wrap; occupancy counter is log2(DEPTH)+1 bits.
  - When empty, out_data holds its last value (0 after reset).
- rx_count saturates and never wraps.
- At most one transaction is in flight. RtoB_ACK changes only on the edges defined above and never glitches.

Test Plan:
1. Reset, DATA_DLY=1, ACK_DLY=1, single transfer with DO=0 and out_ready=1:
   - RtoB_ACK rises 1 edge after REQ is sampled high, and falls 1 edge after REQ is sampled low.
   - out_valid pulses with out_data = 0; rx_count = 1; seq_err = 0; proto_err = 0.
2. 100 back-to-back four-phase transfers with DO = 0..99 and out_ready=1:
   - Consumer receives 0..99 in order.
   - rx_count = 100; seq_err = 0; proto_err = 0.
3. DEPTH=4, out_ready=0, 5 transfers with DO = 0..4:
   - Four words are acknowledged; on the 5th, REQ is held high and RtoB_ACK stays 0 for 20 cycles.
   - Pulse out_ready for one cycle: out_data = 0 is popped, then the 5th word is accepted; occupancy = 4.
4. Words 0, 1, 3, 4:
   - seq_err goes to 1 on the edge that captures 3.
   - No further change on 4 (the check has resynced); seq_err stays 1 until rst; rx_count = 4.
5. DATA_DLY=3, REQ dropped 2 cycles after rising:
   - proto_err = 1; RtoB_ACK never rises; FIFO stays empty; rx_count = 0.
   - A following legal transfer of 0 completes normally.
6. rst asserted for one cycle while in WAIT_LOW with 2 words buffered:
   - After that edge: RtoB_ACK = 0, out_valid = 0, rx_count = 0, errors = 0.
   - A new transfer of 0 completes with seq_err = 0.
